pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits (>=2).
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline depth; WIDTH mod STAGES == 0; CHUNK = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts operand beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in, used only in add mode.
REQ-010 SHALL have port op  input  1  0 = add (a+b+cin), 1 = subtract (a-b).
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry-out of MSB (subtract: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL accept a beat when in_valid && in_ready; SHALL transfer a result when out_valid && out_ready.
REQ-017 SHALL compute add as a + b + cin and subtract as a + ~b + 1 (cin ignored), full WIDTH+1-bit result split into {cout, sum}.
REQ-018 SHALL set ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), b_eff being b or ~b per op.
REQ-019 SHALL add CHUNK bits per stage: stage k adds chunk k of a and b_eff plus the registered carry from stage k-1 (stage 0 uses the effective carry-in).
REQ-020 SHALL delay not-yet-added chunks through input skew registers and already-added sum chunks through output deskew registers so all chunks of one beat emerge together.
REQ-021 SHALL have latency exactly STAGES cycles from acceptance to out_valid with an unstalled pipeline.
REQ-022 SHALL sustain one beat per cycle when out_ready stays high.
REQ-023 SHALL carry a valid bit per stage; bubbles (no acceptance) propagate as invalid stages and SHALL NOT stall later beats.
REQ-024 SHALL use a single global advance enable en = !out_valid || out_ready; in_ready = en; when en is low all stage registers, carries and valid bits hold.
REQ-025 SHALL hold sum, cout, ovf stable while out_valid && !out_ready.
REQ-026 SHALL preserve beat order; no beat dropped or duplicated under any stall pattern.
REQ-027 SHALL accept a new beat in the same cycle the output beat is taken (en high when out_ready high).
REQ-028 SHALL support STAGES = 1 (single registered full add, latency 1) and STAGES = WIDTH (CHUNK = 1).

Reset
REQ-029 SHALL on rst_n low immediately clear all stage valid bits, out_valid = 0, sum = 0, cout = 0, ovf = 0, all carries = 0.
REQ-030 SHALL discard all in-flight beats on reset mid-operation; in_ready SHALL be 1 during and after reset.
REQ-031 SHALL accept a beat on the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place op encoding constants (OP_ADD, OP_SUB) in shared package adder_pkg.
REQ-033 SHALL implement per-stage CHUNK-bit ripple add in sub-module add_chunk (inputs x, y, ci; outputs s, co), instantiated STAGES times via generate.

Verification (WIDTH=8, STAGES=4 unless noted)
REQ-034 SHALL cover: add 8'hFF + 8'h01, cin=0 -> 4 cycles later sum=8'h00, cout=1, ovf=0.
REQ-035 SHALL cover: add 8'h7F + 8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; add 8'h10 + 8'h20, cin=1 -> sum=8'h31.
REQ-036 SHALL cover: sub 8'h05 - 8'h07 -> sum=8'hFE, cout=0, ovf=0; sub 8'h80 - 8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-037 SHALL cover: 6 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low during stall, all 6 results in order, outputs stable while stalled.
REQ-038 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, none of the 3 results ever appear, next beat returns after 4 cycles.
REQ-039 SHALL cover: STAGES=1 and STAGES=8 builds, 1000 random beats with random in_valid/out_ready -> results match reference a+b+cin / a-b model.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared operation encodings for the pipelined adder
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - CHUNK-bit ripple adder slice with carry in/out
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep chunked add/subtract pipeline with valid/ready
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int NSKEW = (STAGES > 1) ? STAGES - 1 : 1;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ovf_r;

    logic             v_r [STAGES];
    logic             c_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic [WIDTH-1:0] a_r [NSKEW];
    logic [WIDTH-1:0] b_r [NSKEW];

    // One global advance enable: the whole pipe moves or the whole pipe holds.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign b_eff   = (op == OP_SUB) ? ~b : b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] x_full;
        logic [WIDTH-1:0] y_full;
        logic [WIDTH-1:0] s_prev;
        logic             c_prev;
        logic             v_prev;
        logic [CHUNK-1:0] s_chunk;
        logic             co;

        if (k == 0) begin : g_first
            assign x_full = a;
            assign y_full = b_eff;
            assign s_prev = '0;
            assign c_prev = cin_eff;
            assign v_prev = in_valid;
        end else begin : g_next
            assign x_full = a_r[k-1];
            assign y_full = b_r[k-1];
            assign s_prev = s_r[k-1];
            assign c_prev = c_r[k-1];
            assign v_prev = v_r[k-1];
        end

        add_chunk #(.CHUNK(CHUNK)) u_add (
            .x  (x_full[k*CHUNK +: CHUNK]),
            .y  (y_full[k*CHUNK +: CHUNK]),
            .ci (c_prev),
            .s  (s_chunk),
            .co (co)
        );

        // Completed low chunks ride along (deskew) while this stage fills its own slice.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r[k] <= 1'b0;
                c_r[k] <= 1'b0;
                s_r[k] <= '0;
            end else if (en) begin
                v_r[k]                    <= v_prev;
                c_r[k]                    <= co;
                s_r[k]                    <= s_prev;
                s_r[k][k*CHUNK +: CHUNK]  <= s_chunk;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r[k] <= '0;
                    b_r[k] <= '0;
                end else if (en) begin
                    a_r[k] <= x_full;
                    b_r[k] <= y_full;
                end
            end
        end else begin : g_last
            // The final stage sees both operand MSBs, so overflow is resolved here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (en) begin
                    ovf_r <= (x_full[WIDTH-1] == y_full[WIDTH-1]) &&
                             (s_chunk[CHUNK-1] != x_full[WIDTH-1]);
                end
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign sum       = s_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule
